// File: rtl/cache_line_engine.sv
// Line-transfer engine: optional 4-word victim writeback followed by a 4-word
// line fill over a single word-wide memory port with MEM_LAT-cycle read latency.
module cache_line_engine #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic        req_wb,
    input  logic [31:0] req_fill_addr,
    input  logic [31:0] req_wb_addr,
    input  logic [31:0] wb_w0,
    input  logic [31:0] wb_w1,
    input  logic [31:0] wb_w2,
    input  logic [31:0] wb_w3,
    output logic        busy,
    output logic        done,
    output logic [31:0] fill_w0,
    output logic [31:0] fill_w1,
    output logic [31:0] fill_w2,
    output logic [31:0] fill_w3,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_r, state_s;
    logic [1:0]   k_r, k_s;
    logic [27:0]  fb_r, wbb_r;
    logic [31:0]  wbw_r  [4];
    logic [31:0]  fill_r [4];
    logic [MEM_LAT-1:0] vld_r;
    logic [1:0]   tag_r  [MEM_LAT];
    logic         cap_vld_s;
    logic [1:0]   cap_tag_s;
    logic         accept_s;

    // Line offsets are ignored: only the 16-byte line base is kept.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{req_fill_addr[3:0], req_wb_addr[3:0]};

    assign accept_s  = (state_r == IDLE) && req_valid;
    assign cap_vld_s = vld_r[MEM_LAT-1];
    assign cap_tag_s = tag_r[MEM_LAT-1];

    assign busy     = (state_r != IDLE);
    assign done     = (state_r == DONE);
    assign mem_size = 2'b10;
    assign fill_w0  = fill_r[0];
    assign fill_w1  = fill_r[1];
    assign fill_w2  = fill_r[2];
    assign fill_w3  = fill_r[3];

    // Next-state and word-counter logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        case (state_r)
            IDLE: begin
                k_s = 2'd0;
                if (req_valid) begin
                    state_s = req_wb ? WB : FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            WB: begin
                k_s = k_r + 2'd1;
                if (k_r == 2'd3) begin
                    state_s = FILL;
                end else begin
                    state_s = WB;
                end
            end
            FILL: begin
                k_s = k_r + 2'd1;
                if (k_r == 2'd3) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                k_s = 2'd0;
                // Leave only once the final word is being captured this edge.
                if (cap_vld_s && (cap_tag_s == 2'd3)) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                k_s     = 2'd0;
                state_s = IDLE;
            end
            default: begin
                k_s     = 2'd0;
                state_s = IDLE;
            end
        endcase
    end

    // Memory port strobes, address and write data decoded from state and k.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        case (state_r)
            WB: begin
                mem_wr   = 1'b1;
                mem_addr = {wbb_r, k_r, 2'b00};
                mem_din  = wbw_r[k_r];
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {fb_r, k_r, 2'b00};
            end
            default: begin
                mem_rd   = 1'b0;
                mem_wr   = 1'b0;
                mem_addr = 32'd0;
                mem_din  = 32'd0;
            end
        endcase
    end

    // State and word counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            k_r     <= 2'd0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
        end
    end

    // Request capture at accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fb_r  <= 28'd0;
            wbb_r <= 28'd0;
            for (int i = 0; i < 4; i++) begin
                wbw_r[i] <= 32'd0;
            end
        end else if (accept_s) begin
            fb_r     <= req_fill_addr[31:4];
            wbb_r    <= req_wb_addr[31:4];
            wbw_r[0] <= wb_w0;
            wbw_r[1] <= wb_w1;
            wbw_r[2] <= wb_w2;
            wbw_r[3] <= wb_w3;
        end else begin
            fb_r  <= fb_r;
            wbb_r <= wbb_r;
        end
    end

    // Read-tag pipeline matching the memory latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_r <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                tag_r[i] <= 2'd0;
            end
        end else begin
            vld_r[0] <= (state_r == FILL);
            tag_r[0] <= k_r;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Fill-word capture as tags emerge from the pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                fill_r[i] <= 32'd0;
            end
        end else if (cap_vld_s) begin
            fill_r[cap_tag_s] <= mem_dout;
        end else begin
            fill_r[0] <= fill_r[0];
        end
    end

endmodule

// File: tb/tb_cache_line_engine.sv
// Directed bench for cache_line_engine: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each backed by a small word memory model with matching read latency.
module tb_cache_line_engine;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic        req_valid, req_wb;
    logic [31:0] req_fill_addr, req_wb_addr, wb_w0, wb_w1, wb_w2, wb_w3;
    logic        busy, done, mem_rd, mem_wr;
    logic [31:0] fill_w0, fill_w1, fill_w2, fill_w3, mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_size;

    logic        l3_req_valid;
    logic [31:0] l3_req_fill_addr;
    logic        l3_busy, l3_done, l3_mem_rd, l3_mem_wr;
    logic [31:0] l3_fill_w0, l3_fill_w1, l3_fill_w2, l3_fill_w3, l3_mem_addr, l3_mem_din, l3_mem_dout;
    logic [1:0]  l3_mem_size;

    cache_line_engine #(.MEM_LAT(1)) u_dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_wb(req_wb),
        .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
        .wb_w0(wb_w0), .wb_w1(wb_w1), .wb_w2(wb_w2), .wb_w3(wb_w3),
        .busy(busy), .done(done),
        .fill_w0(fill_w0), .fill_w1(fill_w1), .fill_w2(fill_w2), .fill_w3(fill_w3),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
        .mem_size(mem_size), .mem_dout(mem_dout)
    );

    cache_line_engine #(.MEM_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .req_valid(l3_req_valid), .req_wb(1'b0),
        .req_fill_addr(l3_req_fill_addr), .req_wb_addr(32'd0),
        .wb_w0(32'd0), .wb_w1(32'd0), .wb_w2(32'd0), .wb_w3(32'd0),
        .busy(l3_busy), .done(l3_done),
        .fill_w0(l3_fill_w0), .fill_w1(l3_fill_w1), .fill_w2(l3_fill_w2), .fill_w3(l3_fill_w3),
        .mem_addr(l3_mem_addr), .mem_rd(l3_mem_rd), .mem_wr(l3_mem_wr), .mem_din(l3_mem_din),
        .mem_size(l3_mem_size), .mem_dout(l3_mem_dout)
    );

    // Memory models; contents are (re)loaded while RST is high.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                mem1[8'h40 + i] <= 32'hA0 + i;
                mem1[8'h80 + i] <= 32'hB0 + i;
            end
            pipe1 <= 32'd0;
        end else begin
            if (mem_wr) mem1[mem_addr[9:2]] <= mem_din;
            pipe1 <= mem_rd ? mem1[mem_addr[9:2]] : 32'd0;
        end
    end
    assign mem_dout = pipe1;

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'd0;
            for (int i = 0; i < 4; i++) mem3[8'hC0 + i] <= 32'hC0 + i;
            for (int i = 0; i < 3; i++) pipe3[i] <= 32'd0;
        end else begin
            if (l3_mem_wr) mem3[l3_mem_addr[9:2]] <= l3_mem_din;
            pipe3[0] <= l3_mem_rd ? mem3[l3_mem_addr[9:2]] : 32'd0;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign l3_mem_dout = pipe3[2];

    wire [67:0] sig1 = {busy, done, mem_rd, mem_wr, mem_addr, mem_din};
    wire [67:0] sig3 = {l3_busy, l3_done, l3_mem_rd, l3_mem_wr, l3_mem_addr, l3_mem_din};

    task automatic test_reset();
        RST = 1'b1;
        req_valid = 1'b0; req_wb = 1'b0; req_fill_addr = 32'd0; req_wb_addr = 32'd0;
        wb_w0 = 32'd0; wb_w1 = 32'd0; wb_w2 = 32'd0; wb_w3 = 32'd0;
        l3_req_valid = 1'b0; l3_req_fill_addr = 32'd0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (sig1 !== 68'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", sig1); end
        n_cmp++;
        if (sig3 !== 68'd0) begin n_bad++; $display("FAIL reset_outputs_lat3: got %h expected 0", sig3); end
        n_cmp++;
        if ({fill_w0, fill_w1, fill_w2, fill_w3} !== 128'd0) begin
            n_bad++; $display("FAIL reset_fill: got %h expected 0", {fill_w0, fill_w1, fill_w2, fill_w3});
        end
        n_cmp++;
        if (mem_size !== 2'b10 || l3_mem_size !== 2'b10) begin
            n_bad++; $display("FAIL mem_size: got %b/%b expected 10", mem_size, l3_mem_size);
        end
    endtask

    task automatic test_fill_only();
        logic [67:0] exp;
        logic [31:0] fw [4];
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h0000_010C; req_wb_addr = 32'hDEAD_BEE0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK);
            exp = 68'd0;
            if (c >= 1 && c <= 6) exp[67] = 1'b1;
            if (c == 6) exp[66] = 1'b1;
            if (c >= 1 && c <= 4) begin exp[65] = 1'b1; exp[63:32] = 32'(32'h100 + 4 * (c - 1)); end
            n_cmp++;
            if (sig1 !== exp) begin n_bad++; $display("FAIL fill_only cycle %0d: got %h expected %h", c, sig1, exp); end
            @(posedge CLK); #1;
            req_valid = 1'b0;
        end
        fw = '{fill_w0, fill_w1, fill_w2, fill_w3};
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (fw[j] !== 32'(32'hA0 + j)) begin n_bad++; $display("FAIL fill_only word%0d: got %h expected %h", j, fw[j], 32'hA0 + j); end
        end
    endtask

    task automatic test_wb_fill();
        logic [67:0] exp;
        logic [31:0] wv [4];
        logic [31:0] fw [4];
        wv = '{32'h11, 32'h22, 32'h33, 32'h44};
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b1; req_fill_addr = 32'h100; req_wb_addr = 32'h240;
        wb_w0 = wv[0]; wb_w1 = wv[1]; wb_w2 = wv[2]; wb_w3 = wv[3];
        for (int c = 0; c <= 12; c++) begin
            @(negedge CLK);
            exp = 68'd0;
            if (c >= 1 && c <= 10) exp[67] = 1'b1;
            if (c == 10) exp[66] = 1'b1;
            if (c >= 1 && c <= 4) begin
                exp[64] = 1'b1; exp[63:32] = 32'(32'h240 + 4 * (c - 1)); exp[31:0] = wv[c - 1];
            end
            if (c >= 5 && c <= 8) begin exp[65] = 1'b1; exp[63:32] = 32'(32'h100 + 4 * (c - 5)); end
            n_cmp++;
            if (sig1 !== exp) begin n_bad++; $display("FAIL wb_fill cycle %0d: got %h expected %h", c, sig1, exp); end
            @(posedge CLK); #1;
            req_valid = 1'b0; wb_w0 = 32'hFFFF_FFFF; wb_w1 = 32'hFFFF_FFFF;
        end
        fw = '{fill_w0, fill_w1, fill_w2, fill_w3};
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (fw[j] !== 32'(32'hA0 + j)) begin n_bad++; $display("FAIL wb_fill word%0d: got %h expected %h", j, fw[j], 32'hA0 + j); end
            n_cmp++;
            if (mem1[8'h90 + j] !== wv[j]) begin n_bad++; $display("FAIL wb_mem word%0d: got %h expected %h", j, mem1[8'h90 + j], wv[j]); end
        end
    endtask

    task automatic test_lat3();
        logic [67:0] exp;
        logic [31:0] fw [4];
        logic [31:0] ev;
        @(posedge CLK); #1;
        l3_req_valid = 1'b1; l3_req_fill_addr = 32'h304;
        for (int c = 0; c <= 10; c++) begin
            @(negedge CLK);
            exp = 68'd0;
            if (c >= 1 && c <= 8) exp[67] = 1'b1;
            if (c == 8) exp[66] = 1'b1;
            if (c >= 1 && c <= 4) begin exp[65] = 1'b1; exp[63:32] = 32'(32'h300 + 4 * (c - 1)); end
            n_cmp++;
            if (sig3 !== exp) begin n_bad++; $display("FAIL lat3 cycle %0d: got %h expected %h", c, sig3, exp); end
            if (c >= 4 && c <= 8) begin
                fw = '{l3_fill_w0, l3_fill_w1, l3_fill_w2, l3_fill_w3};
                for (int j = 0; j < 4; j++) begin
                    ev = (c >= 5 + j) ? 32'(32'hC0 + j) : 32'd0;
                    n_cmp++;
                    if (fw[j] !== ev) begin n_bad++; $display("FAIL lat3_capture cycle %0d word%0d: got %h expected %h", c, j, fw[j], ev); end
                end
            end
            @(posedge CLK); #1;
            l3_req_valid = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        int n_done = 0;
        int n_rd = 0;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h100;
        for (int c = 0; c <= 20; c++) begin
            @(negedge CLK);
            if (done) n_done++;
            if (mem_rd) n_rd++;
            @(posedge CLK); #1;
            req_valid = (c + 1 == 3);
            req_fill_addr = (c + 1 == 3) ? 32'h200 : 32'h100;
        end
        n_cmp++;
        if (n_done !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
        n_cmp++;
        if (n_rd !== 4) begin n_bad++; $display("FAIL ignore_rd_count: got %0d expected 4", n_rd); end
        n_cmp++;
        if (fill_w3 !== 32'hA3) begin n_bad++; $display("FAIL ignore_fill_w3: got %h expected a3", fill_w3); end
    endtask

    task automatic test_back_to_back();
        logic [67:0] exp;
        logic [31:0] fw [4];
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h100;
        for (int c = 0; c <= 15; c++) begin
            @(negedge CLK);
            exp = 68'd0;
            if ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)) exp[67] = 1'b1;
            if (c == 6 || c == 13) exp[66] = 1'b1;
            if (c >= 1 && c <= 4) begin exp[65] = 1'b1; exp[63:32] = 32'(32'h100 + 4 * (c - 1)); end
            if (c >= 8 && c <= 11) begin exp[65] = 1'b1; exp[63:32] = 32'(32'h200 + 4 * (c - 8)); end
            n_cmp++;
            if (sig1 !== exp) begin n_bad++; $display("FAIL back_to_back cycle %0d: got %h expected %h", c, sig1, exp); end
            if (c == 7) begin
                n_cmp++;
                if (fill_w2 !== 32'hA2) begin n_bad++; $display("FAIL b2b_first_hold: got %h expected a2", fill_w2); end
            end
            @(posedge CLK); #1;
            req_fill_addr = 32'h200;
            if (c == 7) req_valid = 1'b0;
        end
        fw = '{fill_w0, fill_w1, fill_w2, fill_w3};
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (fw[j] !== 32'(32'hB0 + j)) begin n_bad++; $display("FAIL b2b_word%0d: got %h expected %h", j, fw[j], 32'hB0 + j); end
        end
    endtask

    task automatic test_rst_mid();
        int n_done = 0;
        int n_rd = 0;
        int done_cyc = -1;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b1; req_fill_addr = 32'h100; req_wb_addr = 32'h240;
        for (int c = 0; c <= 5; c++) begin
            @(posedge CLK); #1;
            req_valid = 1'b0;
            if (c + 1 == 6) RST = 1'b1;
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (sig1 !== 68'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h expected 0", sig1); end
        n_cmp++;
        if ({fill_w0, fill_w1, fill_w2, fill_w3} !== 128'd0) begin
            n_bad++; $display("FAIL rst_mid_fill: got %h expected 0", {fill_w0, fill_w1, fill_w2, fill_w3});
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (done) n_done++;
            if (mem_rd || mem_wr) n_rd++;
        end
        n_cmp++;
        if (n_done !== 0 || n_rd !== 0) begin n_bad++; $display("FAIL rst_mid_quiet: got done=%0d strobes=%0d expected 0/0", n_done, n_rd); end
        @(posedge CLK); #1;
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h208;
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK);
            if (done && done_cyc < 0) done_cyc = c;
            @(posedge CLK); #1;
            req_valid = 1'b0;
        end
        n_cmp++;
        if (done_cyc !== 6) begin n_bad++; $display("FAIL rst_mid_recover_done: got cycle %0d expected 6", done_cyc); end
        n_cmp++;
        if ({fill_w0, fill_w1, fill_w2, fill_w3} !== {32'hB0, 32'hB1, 32'hB2, 32'hB3}) begin
            n_bad++; $display("FAIL rst_mid_recover_fill: got %h expected b0..b3", {fill_w0, fill_w1, fill_w2, fill_w3});
        end
    endtask

    task automatic test_rst_with_req();
        int n_busy = 0;
        @(posedge CLK); #1;
        RST = 1'b1; req_valid = 1'b1; req_wb = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (busy || mem_wr || mem_rd) n_busy++;
        end
        n_cmp++;
        if (n_busy !== 0) begin n_bad++; $display("FAIL rst_with_req: got %0d active cycles expected 0", n_busy); end
    endtask

    initial begin
        test_reset();
        test_fill_only();
        test_wb_fill();
        test_lat3();
        test_ignore_busy();
        test_back_to_back();
        test_rst_mid();
        test_rst_with_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
